disp_share_arbiter: RTL and testbench

Time-shares the four-digit seven-segment display between up to N_SRC independent 8-bit value producers. The block sits directly in front of the display driver's 8-bit `num` input. It grants the display to one requesting source at a time in round-robin order, holds each grant for a programmable dwell period, and forwards the granted source's value every cycle. Sources that stop requesting release the display early, and an external `hold` input freezes rotation on the current source.

---
 rtl/disp_share_arbiter.sv | 121 ++++++++++++
 tb/tb_disp_share_arbiter.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/disp_share_arbiter.sv
// rtl/disp_share_arbiter.sv - round-robin time-share of the 7-segment display between value producers
module disp_share_arbiter #(
    parameter int N_SRC = 4,
    parameter int DWELL = 50_000_000,
    parameter int SRC_W = $clog2(N_SRC),
    parameter int CNT_W = $clog2(DWELL)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_SRC-1:0]     req,
    input  logic [8*N_SRC-1:0]   data,
    input  logic                 hold,
    output logic [N_SRC-1:0]     grant,
    output logic [7:0]           num_out,
    output logic [SRC_W-1:0]     src_id,
    output logic                 upd
);

    typedef enum logic {
        IDLE = 1'b0,
        SHOW = 1'b1
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [SRC_W-1:0]   last;
    logic [SRC_W-1:0]   last_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_nxt;
    logic [N_SRC-1:0]   grant_nxt;
    logic [7:0]         num_nxt;
    logic [SRC_W-1:0]   src_nxt;
    logic               upd_nxt;

    logic [7:0]         data_arr [N_SRC];
    logic               win_vld;
    logic [SRC_W-1:0]   win;
    logic [SRC_W-1:0]   cand;
    logic               early;
    logic               expire;

    genvar gi;
    generate
        for (gi = 0; gi < N_SRC; gi++) begin : g_unpack
            assign data_arr[gi] = data[8*gi +: 8];
        end
    endgenerate

    // Round-robin search starting just after the most recently granted source;
    // the last candidate examined is the previous owner itself, which gives re-grant.
    always_comb begin
        win_vld = 1'b0;
        win     = '0;
        cand    = '0;
        for (int k = 1; k <= N_SRC; k++) begin
            cand = SRC_W'((int'(last) + k) % N_SRC);
            if (!win_vld && req[cand]) begin
                win_vld = 1'b1;
                win     = cand;
            end
        end
    end

    assign early  = !req[src_id];
    assign expire = (cnt == CNT_W'(DWELL - 1)) && !hold;

    // Next-state and next-output decode; a release re-arbitrates in the same edge
    // so early release and expiry together still yield a single grant event.
    always_comb begin
        state_nxt = state;
        last_nxt  = last;
        cnt_nxt   = cnt;
        grant_nxt = grant;
        num_nxt   = num_out;
        src_nxt   = src_id;
        upd_nxt   = 1'b0;
        if (state == SHOW && !(early || expire)) begin
            num_nxt = data_arr[src_id];
            if (!hold) begin
                cnt_nxt = cnt + CNT_W'(1);
            end
        end else if (win_vld) begin
            state_nxt = SHOW;
            last_nxt  = win;
            cnt_nxt   = '0;
            grant_nxt = {{(N_SRC-1){1'b0}}, 1'b1} << win;
            num_nxt   = data_arr[win];
            src_nxt   = win;
            upd_nxt   = 1'b1;
        end else begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
            grant_nxt = '0;
            num_nxt   = '0;
            src_nxt   = '0;
        end
    end

    // State, pointer, dwell counter and registered outputs; last resets to the
    // top index so source 0 is scanned first after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            last    <= SRC_W'(N_SRC - 1);
            cnt     <= '0;
            grant   <= '0;
            num_out <= '0;
            src_id  <= '0;
            upd     <= 1'b0;
        end else begin
            state   <= state_nxt;
            last    <= last_nxt;
            cnt     <= cnt_nxt;
            grant   <= grant_nxt;
            num_out <= num_nxt;
            src_id  <= src_nxt;
            upd     <= upd_nxt;
        end
    end

endmodule

// File: tb/tb_disp_share_arbiter.sv
// tb/tb_disp_share_arbiter.sv - self-checking bench for disp_share_arbiter
module tb_disp_share_arbiter;

    localparam int N  = 4;
    localparam int DW = 4;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req;
    logic [8*N-1:0] data;
    logic           hold;
    logic [N-1:0]   grant;
    logic [7:0]     num_out;
    logic [1:0]     src_id;
    logic           upd;

    int n_vec = 0;
    int n_err = 0;

    // reference model: who owns the display, for how many dwell cycles, and what it shows
    bit         m_busy;
    int         m_owner;
    int         m_last;
    int         m_age;
    logic [7:0] m_num;
    bit         m_upd;

    disp_share_arbiter #(.N_SRC(N), .DWELL(DW)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .data    (data),
        .hold    (hold),
        .grant   (grant),
        .num_out (num_out),
        .src_id  (src_id),
        .upd     (upd)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] dbyte(int i);
        return data[8*i +: 8];
    endfunction

    function automatic logic [N-1:0] exp_grant();
        logic [N-1:0] g;
        g = '0;
        if (m_busy) g[m_owner] = 1'b1;
        return g;
    endfunction

    task automatic model_reset();
        m_busy  = 0;
        m_owner = 0;
        m_last  = N - 1;
        m_age   = 0;
        m_num   = 8'h00;
        m_upd   = 0;
    endtask

    task automatic model_edge();
        bit rel;
        int w;
        m_upd = 0;
        rel = m_busy ? (!req[m_owner] || (m_age == DW - 1 && !hold)) : 1'b1;
        if (!rel) begin
            m_num = dbyte(m_owner);
            if (!hold) m_age++;
        end else begin
            w = -1;
            for (int k = 1; k <= N; k++) begin
                if (w < 0 && req[(m_last + k) % N]) w = (m_last + k) % N;
            end
            if (w >= 0) begin
                m_busy = 1; m_owner = w; m_last = w; m_age = 0;
                m_num = dbyte(w); m_upd = 1;
            end else begin
                m_busy = 0; m_owner = 0; m_age = 0; m_num = 8'h00;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req   = '0;
        hold  = 1'b0;
        data  = '0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        if (grant !== 4'b0000) begin $display("FAIL reset_grant: got %b want 0000", grant); n_err++; end
        n_vec++;
        if (num_out !== 8'h00) begin $display("FAIL reset_num: got %h want 00", num_out); n_err++; end
        n_vec++;
        if (src_id !== 2'd0 || upd !== 1'b0) begin
            $display("FAIL reset_src_upd: got src=%0d upd=%b want 0/0", src_id, upd); n_err++;
        end
        n_vec++;
    endtask

    task automatic test_single();
        do_reset();
        req = 4'b0100;
        data = {8'h44, 8'h2A, 8'h22, 8'h11};
        step();
        if (grant !== 4'b0100 || src_id !== 2'd2 || num_out !== 8'h2A || upd !== 1'b1) begin
            $display("FAIL single_first: got g=%b s=%0d n=%h u=%b want 0100/2/2a/1", grant, src_id, num_out, upd);
            n_err++;
        end
        n_vec++;
        for (int c = 1; c <= 8; c++) begin
            step();
            if (grant !== 4'b0100 || upd !== (c % 4 == 0)) begin
                $display("FAIL single_regrant c=%0d: got g=%b u=%b want 0100/%b", c, grant, upd, (c % 4 == 0));
                n_err++;
            end
            n_vec++;
        end
    endtask

    task automatic test_rotation();
        logic [N-1:0] eg;
        int o;
        do_reset();
        data = $urandom;
        req  = 4'b1111;
        for (int g = 0; g < 20; g++) begin
            step();
            o  = (g / 4) % 4;
            eg = 4'b0001 << o;
            if (grant !== eg || upd !== (g % 4 == 0) || num_out !== dbyte(o)) begin
                $display("FAIL rotation g=%0d: got g=%b u=%b n=%h want %b/%b/%h", g, grant, upd, num_out, eg, (g % 4 == 0), dbyte(o));
                n_err++;
            end
            n_vec++;
        end
    endtask

    task automatic test_early_release();
        do_reset();
        data = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
        req  = 4'b1010;
        step();
        if (grant !== 4'b0010) begin $display("FAIL early_first: got %b want 0010", grant); n_err++; end
        n_vec++;
        step();
        step();
        req = 4'b1000;
        step();
        if (grant !== 4'b1000 || num_out !== 8'hD3 || upd !== 1'b1) begin
            $display("FAIL early_switch: got g=%b n=%h u=%b want 1000/d3/1", grant, num_out, upd); n_err++;
        end
        n_vec++;
        for (int c = 1; c <= 4; c++) begin
            step();
            if (upd !== (c == 4) || grant !== 4'b1000) begin
                $display("FAIL early_restart c=%0d: got g=%b u=%b want 1000/%b", c, grant, upd, (c == 4)); n_err++;
            end
            n_vec++;
        end
    endtask

    task automatic test_hold();
        do_reset();
        data = $urandom;
        req  = 4'b0011;
        step();
        step();
        hold = 1'b1;
        for (int c = 0; c < 10; c++) begin
            step();
            if (grant !== 4'b0001 || upd !== 1'b0) begin
                $display("FAIL hold_frozen c=%0d: got g=%b u=%b want 0001/0", c, grant, upd); n_err++;
            end
            n_vec++;
        end
        hold = 1'b0;
        step();
        step();
        if (grant !== 4'b0001) begin $display("FAIL hold_remaining: got %b want 0001", grant); n_err++; end
        n_vec++;
        step();
        if (grant !== 4'b0010 || upd !== 1'b1 || num_out !== dbyte(1)) begin
            $display("FAIL hold_expiry: got g=%b u=%b n=%h want 0010/1/%h", grant, upd, num_out, dbyte(1)); n_err++;
        end
        n_vec++;
    endtask

    task automatic test_empty();
        do_reset();
        data = 32'hFFEEDDCC;
        req  = 4'b0110;
        step();
        step();
        req = 4'b0000;
        step();
        if (grant !== 4'b0000 || num_out !== 8'h00 || src_id !== 2'd0 || upd !== 1'b0) begin
            $display("FAIL empty_idle: got g=%b n=%h s=%0d u=%b want 0000/00/0/0", grant, num_out, src_id, upd); n_err++;
        end
        n_vec++;
    endtask

    task automatic test_async_reset();
        do_reset();
        data = 32'h5A6B7C8D;
        req  = 4'b1111;
        for (int c = 0; c < 6; c++) step();
        if (grant !== 4'b0010) begin $display("FAIL arst_pre: got %b want 0010", grant); n_err++; end
        n_vec++;
        #2 rst_n = 1'b0;
        #1;
        if (grant !== 4'b0000 || num_out !== 8'h00 || upd !== 1'b0 || src_id !== 2'd0) begin
            $display("FAIL arst_immediate: got g=%b n=%h u=%b s=%0d want zeros", grant, num_out, upd, src_id); n_err++;
        end
        n_vec++;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        step();
        if (grant !== 4'b0001 || upd !== 1'b1 || num_out !== 8'h8D) begin
            $display("FAIL arst_first: got g=%b u=%b n=%h want 0001/1/8d", grant, upd, num_out); n_err++;
        end
        n_vec++;
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 9) == 0) req = 4'b0000;
            hold = ($urandom_range(0, 4) == 0);
            data = $urandom;
            step();
            if (grant !== exp_grant() || src_id !== 2'(m_owner) || num_out !== m_num || upd !== m_upd) begin
                $display("FAIL random c=%0d: got g=%b s=%0d n=%h u=%b want %b/%0d/%h/%b",
                         c, grant, src_id, num_out, upd, exp_grant(), m_owner, m_num, m_upd);
                n_err++;
            end
            n_vec++;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        req   = '0;
        hold  = 1'b0;
        data  = '0;
        model_reset();
        test_reset();
        test_single();
        test_rotation();
        test_early_release();
        test_hold();
        test_empty();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
